shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Shift-register sequencer: a parallel load, then left/right sweeps of a position
// pointer, with each step paced by a tick pulse.
module shift_sequencer #(
  parameter int N  = 8,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  seed,
  input  logic [3:0]    sweeps,
  output logic [1:0]    ctrl,
  output logic [N-1:0]  data,
  output logic [PW-1:0] pos,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, LEFT, RIGHT} state_t;

  localparam logic [1:0] C_HOLD  = 2'b00;
  localparam logic [1:0] C_RIGHT = 2'b01;
  localparam logic [1:0] C_LEFT  = 2'b10;
  localparam logic [1:0] C_LOAD  = 2'b11;

  localparam logic [PW-1:0] POS_MAX = PW'(N-1);

  state_t        state, state_n;
  logic [PW-1:0] pos_n;
  logic [3:0]    cnt, cnt_n, target, target_n;
  logic [N-1:0]  data_n;
  logic          done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pos    <= '0;
      cnt    <= '0;
      target <= '0;
      data   <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      cnt    <= cnt_n;
      target <= target_n;
      data   <= data_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    cnt_n    = cnt;
    target_n = target;
    data_n   = data;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        // Acceptance ignores tick, so a coincident tick never reaches the load.
        if (start && !stop) begin
          state_n  = LOAD;
          data_n   = seed;
          target_n = sweeps;
          cnt_n    = '0;
        end
      end
      LOAD: begin
        if (tick) begin
          pos_n   = '0;
          state_n = LEFT;
        end
      end
      LEFT: begin
        if (tick) begin
          pos_n = pos + 1'b1;
          if (pos_n == POS_MAX) state_n = RIGHT;
        end
      end
      RIGHT: begin
        if (tick) begin
          pos_n = pos - 1'b1;
          if (pos_n == '0) begin
            cnt_n = cnt + 4'd1;
            // A target of zero never matches, so the count just wraps.
            if (target != 4'd0 && cnt_n == target) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = LEFT;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop && state != IDLE) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  always_comb begin
    ctrl = C_HOLD;
    if (tick && !stop && !reset) begin
      case (state)
        LOAD:    ctrl = C_LOAD;
        LEFT:    ctrl = C_LEFT;
        RIGHT:   ctrl = C_RIGHT;
        default: ctrl = C_HOLD;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
